// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer
// Byte-to-nibble write sequencer for an HD44780-style LCD in 4-bit mode.
// Accepts one command/data byte per valid/ready handshake and sends it as
// two nibbles (high first), each with its own setup / E-high / hold window,
// followed by a post-write wait (long wait for clear/home commands).
//
// Optional feature: define LCD_INIT_SEQ_EN to have the block run the LCD
// power-on initialisation (power-up delay, 3,3,3,2 single nibbles, then
// 0x28, 0x0C, 0x06, 0x01) before it first raises ready.
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-low reset
//   din[7:0]   byte to write
//   rs_in      register select for din (0 = command, 1 = data)
//   valid      din/rs_in valid; transfer on a rising edge with valid && ready
//   ready      registered, high only in IDLE
//   init_done  power-on init complete (constant 1 after reset without the macro)
//   dataout    LCD DB7..DB4
//   control    {RW (always 0), RS, E}
module lcd_nibble_writer #(
    parameter int SETUP_CYC        = 3,
    parameter int E_HIGH_CYC       = 12,
    parameter int HOLD_CYC         = 3,
    parameter int CMD_WAIT_CYC     = 2000,
    parameter int LONG_WAIT_CYC    = 82000,
    parameter int POWERUP_WAIT_CYC = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       rs_in,
    input  logic       valid,
    output logic       ready,
    output logic       init_done,
    output logic [3:0] dataout,
    output logic [2:0] control
);

    localparam int MAX_0 = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int MAX_1 = (MAX_0 > HOLD_CYC) ? MAX_0 : HOLD_CYC;
    localparam int MAX_2 = (MAX_1 > CMD_WAIT_CYC) ? MAX_1 : CMD_WAIT_CYC;
    localparam int MAX_3 = (MAX_2 > LONG_WAIT_CYC) ? MAX_2 : LONG_WAIT_CYC;
    localparam int MAX_ALL = (MAX_3 > POWERUP_WAIT_CYC) ? MAX_3 : POWERUP_WAIT_CYC;
    localparam int CNT_W = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
`ifdef LCD_INIT_SEQ_EN
        ST_WAIT,
        ST_INIT_PWR
`else
        ST_WAIT
`endif
    } state_t;

    // One write job: the byte to send, whether only its high nibble goes out
    // (init single-nibble steps), and which post-write wait follows it.
    typedef struct packed {
        logic       single;
        logic       long_wait;
        logic [7:0] data;
    } job_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             phase_hi_q, phase_hi_d;
    logic             single_q, single_d;
    logic             long_q, long_d;
    logic [3:0]       dataout_q, dataout_d;
    logic             e_q, e_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;

    logic             load;
    job_t             load_job;
    logic             cnt_done;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_step_q, init_step_d;

    function automatic job_t init_rom(input logic [2:0] step);
        case (step)
            3'd0:    return '{single: 1'b1, long_wait: 1'b1, data: 8'h30};
            3'd1:    return '{single: 1'b1, long_wait: 1'b0, data: 8'h30};
            3'd2:    return '{single: 1'b1, long_wait: 1'b0, data: 8'h30};
            3'd3:    return '{single: 1'b1, long_wait: 1'b0, data: 8'h20};
            3'd4:    return '{single: 1'b0, long_wait: 1'b0, data: 8'h28};
            3'd5:    return '{single: 1'b0, long_wait: 1'b0, data: 8'h0C};
            3'd6:    return '{single: 1'b0, long_wait: 1'b0, data: 8'h06};
            default: return '{single: 1'b0, long_wait: 1'b1, data: 8'h01};
        endcase
    endfunction
`endif

    assign cnt_done = (cnt_q == '0);

    // NOTE: every variable gets a default at the top of this block, so no
    // path through the case statements can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        phase_hi_d  = phase_hi_q;
        single_d    = single_q;
        long_d      = long_q;
        dataout_d   = dataout_q;
        init_done_d = init_done_q;
        load        = 1'b0;
        load_job    = '0;
`ifdef LCD_INIT_SEQ_EN
        init_step_d = init_step_q;
`else
        init_done_d = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (valid && ready_q) begin
                    load     = 1'b1;
                    rs_d     = rs_in;
                    load_job = '{single:    1'b0,
                                 long_wait: !rs_in && (din == 8'h01 || din == 8'h02 || din == 8'h03),
                                 data:      din};
                end
            end
            ST_SETUP: if (cnt_done) state_d = ST_EHIGH;
            ST_EHIGH: if (cnt_done) state_d = ST_HOLD;
            ST_HOLD: begin
                if (cnt_done) begin
                    if (phase_hi_q && !single_q) begin
                        state_d    = ST_SETUP;
                        phase_hi_d = 1'b0;
                        dataout_d  = byte_q[3:0];
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
`ifdef LCD_INIT_SEQ_EN
                    if (init_done_q || init_step_q == 3'd7) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        init_step_d = init_step_q + 3'd1;
                        load        = 1'b1;
                        rs_d        = 1'b0;
                        load_job    = init_rom(init_step_q + 3'd1);
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef LCD_INIT_SEQ_EN
            ST_INIT_PWR: begin
                if (cnt_done) begin
                    load     = 1'b1;
                    rs_d     = 1'b0;
                    load_job = init_rom(3'd0);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d    = ST_SETUP;
            byte_d     = load_job.data;
            single_d   = load_job.single;
            long_d     = load_job.long_wait;
            phase_hi_d = 1'b1;
            dataout_d  = load_job.data[7:4];
        end

        // Every state change is a state entry: reload the shared down-counter.
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP: cnt_d = CNT_W'(SETUP_CYC - 1);
                ST_EHIGH: cnt_d = CNT_W'(E_HIGH_CYC - 1);
                ST_HOLD:  cnt_d = CNT_W'(HOLD_CYC - 1);
                ST_WAIT:  cnt_d = long_q ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                default:  cnt_d = '0;
            endcase
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs are registered from the next state so E and ready are glitch-free.
    assign e_d     = (state_d == ST_EHIGH);
    assign ready_d = (state_d == ST_IDLE);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef LCD_INIT_SEQ_EN
            state_q     <= ST_INIT_PWR;
            cnt_q       <= CNT_W'(POWERUP_WAIT_CYC - 1);
            init_step_q <= 3'd0;
`else
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
`endif
            byte_q      <= '0;
            rs_q        <= 1'b0;
            phase_hi_q  <= 1'b0;
            single_q    <= 1'b0;
            long_q      <= 1'b0;
            dataout_q   <= '0;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
`ifdef LCD_INIT_SEQ_EN
            init_step_q <= init_step_d;
`endif
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            phase_hi_q  <= phase_hi_d;
            single_q    <= single_d;
            long_q      <= long_d;
            dataout_q   <= dataout_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign ready     = ready_q;
    assign init_done = init_done_q;
    assign dataout   = dataout_q;
    assign control   = {1'b0, rs_q, e_q};

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with short timing parameters.
// Timing is measured in clock edges from the accept edge; outputs are
// sampled on the falling edge, so sample n reflects the state after edge n.
module tb_lcd_nibble_writer;

    localparam int SETUP = 2;
    localparam int EHIGH = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int LONGW = 50;
    localparam int PWR   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rs_in = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic       init_done;
    logic [3:0] dataout;
    logic [2:0] control;

    always #5 clk = ~clk;

    lcd_nibble_writer #(
        .SETUP_CYC       (SETUP),
        .E_HIGH_CYC      (EHIGH),
        .HOLD_CYC        (HOLD),
        .CMD_WAIT_CYC    (CMDW),
        .LONG_WAIT_CYC   (LONGW),
        .POWERUP_WAIT_CYC(PWR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .rs_in    (rs_in),
        .valid    (valid),
        .ready    (ready),
        .init_done(init_done),
        .dataout  (dataout),
        .control  (control)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observation results
    int         p_cnt;
    logic [3:0] p_nib [16];
    int         p_wid [16];
    int         p_rise[16];
    int         r_cnt;
    int         r_at  [4];
    int         rs_bad;
    int         done_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called on a falling edge. Samples every falling edge, logs E pulses
    // (nibble, width, first-high sample) and samples where ready is high,
    // and stops at the stop_ready-th ready-high sample. valid is dropped at
    // sample valid_until when that is nonzero.
    task automatic observe(input int limit, input int stop_ready, input logic exp_rs,
                           input int valid_until);
        logic prev_e;
        bit   hit;
        prev_e = 1'b0;
        hit    = 1'b0;
        p_cnt = 0; r_cnt = 0; rs_bad = 0; done_bad = 0;
        for (int el = 0; el < limit; el++) begin
            if (el > 0) @(negedge clk);
            if (control[0] === 1'b1) begin
                if (!prev_e) begin
                    if (p_cnt < 16) begin
                        p_nib[p_cnt]  = dataout;
                        p_wid[p_cnt]  = 0;
                        p_rise[p_cnt] = el;
                    end
                    p_cnt++;
                end
                if (p_cnt <= 16) p_wid[p_cnt-1]++;
            end
            prev_e = control[0];
            if (control[1] !== exp_rs || control[2] !== 1'b0) rs_bad++;
            if (init_done !== ready) done_bad++;
            if (valid_until > 0 && el == valid_until) valid = 1'b0;
            if (ready === 1'b1) begin
                if (r_cnt < 4) r_at[r_cnt] = el;
                r_cnt++;
                if (r_cnt == stop_ready) begin
                    hit = 1'b1;
                    break;
                end
            end
        end
        if (!hit) check("observe_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("wait_ready_timeout", 0, 1);
    endtask

    // Waits for ready, presents the byte, and returns on the falling edge
    // right after the accept edge (sample 0).
    task automatic send(input logic [7:0] b, input logic rs);
        wait_ready();
        din   = b;
        rs_in = rs;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on a falling edge with reset low; releases it and checks
    // the block comes up correctly.
    task automatic do_release();
        int e_seen;
`ifdef LCD_INIT_SEQ_EN
        logic [3:0] exp_init [12];
        exp_init = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        // valid with junk during init must be ignored
        din   = 8'h55;
        rs_in = 1'b1;
        valid = 1'b1;
        reset = 1'b1;
        // 20 + 4*8 + 50+3*10 + 3*(16+10) + (16+50) = 276 edges to ready
        observe(600, 1, 1'b0, 276);
        check("init_pulses", p_cnt, 12);
        check("init_first_e", p_rise[0], PWR + SETUP);
        for (int i = 0; i < 12; i++) check($sformatf("init_nib%0d", i), p_nib[i], exp_init[i]);
        check("init_ready_at", r_at[0], 276);
        check("init_rs_rw", rs_bad, 0);
        check("init_done_with_ready", done_bad, 0);
        check("init_done", init_done, 1);
        e_seen = 0;
`else
        reset = 1'b1;
        #1;
        check("ready_before_edge", ready, 0);
        @(negedge clk);
        check("ready_after_1_edge", ready, 1);
        check("init_done_after_1_edge", init_done, 1);
        e_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (control !== 3'b000) e_seen++;
        end
        check("no_stray_e", e_seen, 0);
        check("idle_ready", ready, 1);
`endif
    endtask

    typedef struct {
        logic [7:0] b;
        logic       rs;
        int         cycles;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dataout", dataout, 0);
        check("rst_control", control, 0);
        check("rst_ready", ready, 0);
        check("rst_init_done", init_done, 0);
        do_release();

        // Data byte 0x41; junk on the inputs after accept must be ignored
        send(8'h41, 1'b1);
        din   = 8'hEE;
        rs_in = 1'b0;
        observe(200, 1, 1'b1, 20);
        check("data_pulses", p_cnt, 2);
        check("data_nib_hi", p_nib[0], 4'h4);
        check("data_nib_lo", p_nib[1], 4'h1);
        check("data_wid_hi", p_wid[0], EHIGH);
        check("data_wid_lo", p_wid[1], EHIGH);
        check("data_first_e", p_rise[0], SETUP);
        check("data_second_e", p_rise[1], SETUP + EHIGH + HOLD + SETUP);
        check("data_rs", rs_bad, 0);
        check("data_ready_at", r_at[0], 26);
        check("data_hold_dataout", dataout, 4'h1);

        // Wait-length selection around the clear/home boundary
        vecs = '{'{8'h01, 1'b0, 66}, '{8'h0C, 1'b0, 26}, '{8'h03, 1'b0, 66},
                 '{8'h04, 1'b0, 26}, '{8'h00, 1'b0, 26}, '{8'h01, 1'b1, 26}};
        foreach (vecs[i]) begin
            send(vecs[i].b, vecs[i].rs);
            valid = 1'b0;
            observe(200, 1, vecs[i].rs, 0);
            check($sformatf("wait_%02h_rs%0d", vecs[i].b, vecs[i].rs), r_at[0], vecs[i].cycles);
            check($sformatf("nibs_%02h_rs%0d", vecs[i].b, vecs[i].rs),
                  {p_cnt[7:0], p_nib[0], p_nib[1]}, {8'd2, vecs[i].b});
        end

        // Back-to-back: valid held high, second byte accepted the cycle ready rises
        send(8'h48, 1'b1);
        din = 8'h49;
        observe(200, 2, 1'b1, 27);
        check("b2b_pulses", p_cnt, 4);
        check("b2b_nibs", {p_nib[0], p_nib[1], p_nib[2], p_nib[3]}, 16'h4849);
        check("b2b_ready1", r_at[0], 26);
        check("b2b_third_e", p_rise[2], 26 + 1 + SETUP);
        check("b2b_ready2", r_at[1], 53);

        // Mid-write reset during EHIGH
        send(8'h41, 1'b1);
        valid = 1'b0;
        n = 0;
        while (control[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_e_reached", control[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_control", control, 0);
        check("mid_rst_dataout", dataout, 0);
        check("mid_rst_ready", ready, 0);
        @(negedge clk);
        do_release();

        // Normal operation after the abort
        send(8'h0C, 1'b0);
        valid = 1'b0;
        observe(200, 1, 1'b0, 0);
        check("post_rst_ready_at", r_at[0], 26);
        check("post_rst_nibs", {p_cnt[7:0], p_nib[0], p_nib[1]}, {8'd2, 8'h0C});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Byte-to-nibble write sequencer for the HD44780-style character LCD in 4-bit mode. It sits directly downstream of the I2C master/temperature-formatting logic. It accepts one character or command byte at a time over a valid/ready handshake and drives the `dataout[3:0]` / `control[2:0]` pins with correctly timed E strobes and post-write delays. With the init macro defined, it also runs the LCD power-on initialisation itself before accepting any bytes.

## Interface
- `SETUP_CYC`, default 3: cycles RS/data are stable before E rises (≥1).
- `E_HIGH_CYC`, default 12: cycles E is held high (≥1).
- `HOLD_CYC`, default 3: cycles data/RS are held after E falls (≥1).
- `CMD_WAIT_CYC`, default 2000: idle cycles after a normal byte (≥1).
- `LONG_WAIT_CYC`, default 82000: idle cycles after a clear or home command (≥1).
- `POWERUP_WAIT_CYC`, default 750000: delay before the first init nibble; used only with `LCD_INIT_SEQ_EN`.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- `din` input 8: byte to write.
- `rs_in` input 1: register select, 0 = command, 1 = data.
- `valid` input 1: `din`/`rs_in` are valid.
- `ready` output 1: block can accept a byte; a transfer occurs on a rising edge where `valid && ready`.
- `init_done` output 1: power-on init is complete. Constant 1 after reset when the init macro is undefined.
- `dataout` output 4: LCD DB7..DB4.
- `control` output 3: `control[2]` = RW, always 0; `control[1]` = RS; `control[0]` = E.

## Operation
- Reset value of every output while `reset` is low: `dataout` = 0, `control` = 3'b000, `ready` = 0, `init_done` = 0.
- Asserting reset mid-operation aborts immediately. E drops to 0 asynchronously and no partial nibble is completed.
- States:
  - IDLE
  - SETUP
  - EHIGH
  - HOLD
  - WAIT
  - INIT_PWR, compiled in only with `LCD_INIT_SEQ_EN`
- `ready` = 1 only in IDLE. It is a registered output.
- On accept:
  - Latch `din` and `rs_in`.
  - Set `phase` = high nibble.
  - Go to SETUP with `dataout` = `din[7:4]`, RS = `rs_in`, E = 0.
- SETUP → EHIGH after `SETUP_CYC` cycles; E = 1.
- EHIGH → HOLD after `E_HIGH_CYC` cycles; E = 0.
- HOLD completes after `HOLD_CYC` cycles:
  - If the high nibble was just sent, go to SETUP with `dataout` = low nibble.
  - Otherwise, go to WAIT.
- WAIT → IDLE after its wait count:
  - `LONG_WAIT_CYC` if RS = 0 and the byte is 0x01, 0x02 or 0x03.
  - `CMD_WAIT_CYC` otherwise.
- `dataout` and RS hold their last values through WAIT and IDLE. E is 0 in every state except EHIGH.
- `valid` is ignored whenever `ready` = 0. Input changes after acceptance have no effect.
- A single down-counter is used. Its width is `$clog2` of the largest parameter plus 1. It is reloaded with the parameter value minus 1 on each state entry.

## Timing
- Accept edge to E first rising: `SETUP_CYC` cycles.
- Per nibble: `SETUP_CYC + E_HIGH_CYC + HOLD_CYC` cycles.
- Accept edge to `ready` = 1: `2*(SETUP_CYC+E_HIGH_CYC+HOLD_CYC) + wait` cycles.
- Back-to-back transfers: `valid` held high in IDLE is accepted on the first cycle `ready` is 1, so there are no extra gap cycles.
- Without the macro, `ready` rises on the first rising edge after `reset` deasserts.

## Configuration
- Macro `LCD_INIT_SEQ_EN`.
- Defined:
  - After reset release, stay in INIT_PWR for `POWERUP_WAIT_CYC` cycles with `ready` = 0.
  - Send single nibbles with RS = 0, each with its own SETUP/EHIGH/HOLD:
    - 0x3, then wait `LONG_WAIT_CYC`.
    - 0x3, then wait `CMD_WAIT_CYC`.
    - 0x3, then wait `CMD_WAIT_CYC`.
    - 0x2, then wait `CMD_WAIT_CYC`.
  - Send full command bytes 0x28, 0x0C, 0x06 and 0x01 through the normal path. 0x01 gets `LONG_WAIT_CYC`.
  - Then set `init_done` = 1 and go to IDLE.
- Undefined:
  - INIT_PWR and the init ROM are absent.
  - `init_done` is registered 1 from the first edge after reset release.

## Test plan
All scenarios use SETUP=2, E_HIGH=4, HOLD=2, CMD_WAIT=10, LONG_WAIT=50, POWERUP=20.

- **Reset values:** hold `reset` = 0 → all outputs 0. Release without the macro → `ready` = 1 after one edge.
- **Data byte:** send 0x41 with `rs_in` = 1.
  - E pulses exactly twice, each 4 cycles wide.
  - `dataout` = 0x4 during the first pulse and 0x1 during the second.
  - `control[1]` = 1 throughout.
  - `ready` returns 26 cycles after accept.
- **Long-wait command:** send 0x01 with `rs_in` = 0 → `ready` returns 66 cycles after accept. Sending 0x0C instead → 26 cycles.
- **Back-to-back:** hold `valid` high with 0x48 then 0x49 → the second accept lands on the exact cycle `ready` rises. 4 E pulses total, 0 extra cycles.
- **Mid-write reset:** drop `reset` during EHIGH → E = 0 immediately, and on release the block returns to IDLE with no stray pulse.
- **Init sequence (macro defined):** release reset.
  - No E pulse for 20 cycles.
  - Then 4 single-nibble pulses 3,3,3,2 with RS = 0.
  - Then 8 nibble pulses 2,8,0,C,0,6,0,1.
  - `init_done` = 1 and `ready` = 1 together; `valid` before that point is ignored.
